// File: rtl/tlc_sensor_conditioner.sv
//==============================================================================
// Module      : tlc_sensor_conditioner
// Description : Synchronises and debounces the two raw vehicle detectors and
//               emits arrival pulses and saturating per-approach queue counts.
//               Optional macro SENSOR_HOLD_EN latches demand until served.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tlc_sensor_conditioner #(
    parameter int DEB_CYCLES = 4,
    parameter int CNT_W      = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sensor1_raw,
    input  logic             sensor2_raw,
    input  logic             serve1,
    input  logic             serve2,
    output logic             sensor1,
    output logic             sensor2,
    output logic             arrive1,
    output logic             arrive2,
    output logic [CNT_W-1:0] count1,
    output logic [CNT_W-1:0] count2,
    output logic             overflow
);

    localparam int               c_DEB_W    = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES + 1);
    localparam logic [c_DEB_W-1:0] c_DEB_LAST = c_DEB_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX  = '1;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        CHK_HI    = 2'd1,
        STABLE_HI = 2'd2,
        CHK_LO    = 2'd3
    } deb_state_t;

    logic [1:0]       w_raw;
    logic [1:0]       w_serve;
    logic [1:0]       w_sensor;
    logic [1:0]       w_arrive;
    logic [1:0]       w_ovf_set;
    logic [CNT_W-1:0] w_count [2];
    logic             r_overflow;

    assign w_raw   = {sensor2_raw, sensor1_raw};
    assign w_serve = {serve2, serve1};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ch
            logic             r_s1;
            logic             r_s2;
            deb_state_t       r_state;
            deb_state_t       w_state_nx;
            logic [c_DEB_W-1:0] r_deb_cnt;
            logic [c_DEB_W-1:0] w_deb_cnt_nx;
            logic             w_rise;
            logic             w_stable;
            logic             r_arrive;
            logic [CNT_W-1:0] r_count;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_s1 <= 1'b0;
                    r_s2 <= 1'b0;
                end else begin
                    r_s1 <= w_raw[gi];
                    r_s2 <= r_s1;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_state   <= STABLE_LO;
                    r_deb_cnt <= '0;
                    r_arrive  <= 1'b0;
                end else begin
                    r_state   <= w_state_nx;
                    r_deb_cnt <= w_deb_cnt_nx;
                    r_arrive  <= w_rise;
                end
            end

            // Accepted level: still high while a falling edge is being qualified
            assign w_stable = (r_state == STABLE_HI) || (r_state == CHK_LO);

            always_comb begin
                w_state_nx   = r_state;
                w_deb_cnt_nx = r_deb_cnt;
                w_rise       = 1'b0;
                case (r_state)
                    STABLE_LO: begin
                        if (r_s2) begin
                            if (DEB_CYCLES <= 1) begin
                                w_state_nx = STABLE_HI;
                                w_rise     = 1'b1;
                            end else begin
                                w_state_nx   = CHK_HI;
                                w_deb_cnt_nx = c_DEB_W'(1);
                            end
                        end
                    end
                    CHK_HI: begin
                        if (!r_s2) begin
                            w_state_nx   = STABLE_LO;
                            w_deb_cnt_nx = '0;
                        end else if (r_deb_cnt == c_DEB_LAST) begin
                            w_state_nx   = STABLE_HI;
                            w_deb_cnt_nx = '0;
                            w_rise       = 1'b1;
                        end else begin
                            w_deb_cnt_nx = r_deb_cnt + c_DEB_W'(1);
                        end
                    end
                    STABLE_HI: begin
                        if (!r_s2) begin
                            if (DEB_CYCLES <= 1) begin
                                w_state_nx = STABLE_LO;
                            end else begin
                                w_state_nx   = CHK_LO;
                                w_deb_cnt_nx = c_DEB_W'(1);
                            end
                        end
                    end
                    CHK_LO: begin
                        if (r_s2) begin
                            w_state_nx   = STABLE_HI;
                            w_deb_cnt_nx = '0;
                        end else if (r_deb_cnt == c_DEB_LAST) begin
                            w_state_nx   = STABLE_LO;
                            w_deb_cnt_nx = '0;
                        end else begin
                            w_deb_cnt_nx = r_deb_cnt + c_DEB_W'(1);
                        end
                    end
                    default: begin
                        w_state_nx   = STABLE_LO;
                        w_deb_cnt_nx = '0;
                    end
                endcase
            end

            // A serve coinciding with an arrival clears first, then counts it
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_count <= '0;
                end else if (w_serve[gi] && r_arrive) begin
                    r_count <= CNT_W'(1);
                end else if (w_serve[gi]) begin
                    r_count <= '0;
                end else if (r_arrive && (r_count != c_CNT_MAX)) begin
                    r_count <= r_count + CNT_W'(1);
                end
            end

            assign w_ovf_set[gi] = r_arrive && !w_serve[gi] && (r_count == c_CNT_MAX);
            assign w_arrive[gi]  = r_arrive;
            assign w_count[gi]   = r_count;

`ifdef SENSOR_HOLD_EN
            assign w_sensor[gi] = w_stable | (r_count != '0);
`else
            assign w_sensor[gi] = w_stable;
`endif
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (|w_ovf_set) begin
            r_overflow <= 1'b1;
        end
    end

    assign sensor1  = w_sensor[0];
    assign sensor2  = w_sensor[1];
    assign arrive1  = w_arrive[0];
    assign arrive2  = w_arrive[1];
    assign count1   = w_count[0];
    assign count2   = w_count[1];
    assign overflow = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_tlc_sensor_conditioner.sv
//==============================================================================
// Module      : tb_tlc_sensor_conditioner
// Description : Directed and randomized bench for tlc_sensor_conditioner with
//               a sample-history reference model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_tlc_sensor_conditioner;

    localparam int DEB   = 4;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef SENSOR_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             sensor1_raw = 1'b0;
    logic             sensor2_raw = 1'b0;
    logic             serve1 = 1'b0;
    logic             serve2 = 1'b0;
    logic             sensor1, sensor2, arrive1, arrive2, overflow;
    logic [CNT_W-1:0] count1, count2;

    always #5 clk = ~clk;

    tlc_sensor_conditioner #(
        .DEB_CYCLES (DEB),
        .CNT_W      (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sensor1_raw (sensor1_raw),
        .sensor2_raw (sensor2_raw),
        .serve1      (serve1),
        .serve2      (serve2),
        .sensor1     (sensor1),
        .sensor2     (sensor2),
        .arrive1     (arrive1),
        .arrive2     (arrive2),
        .count1      (count1),
        .count2      (count2),
        .overflow    (overflow)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: bit k of m_hist is the raw value sampled k edges ago; the
    // debouncer sees samples two edges late and needs DEB of them in a row.
    bit [63:0] m_hist   [2];
    bit        m_stable [2];
    bit        m_arr    [2];
    int        m_cnt    [2];
    bit        m_ovf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit raw [2];
        bit sv  [2];
        bit all_diff;
        raw[0] = sensor1_raw; raw[1] = sensor2_raw;
        sv[0]  = serve1;      sv[1]  = serve2;
        if (reset) begin
            for (int c = 0; c < 2; c++) begin
                m_hist[c] = '0; m_stable[c] = 0; m_arr[c] = 0; m_cnt[c] = 0;
            end
            m_ovf = 0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (sv[c] && m_arr[c])  m_cnt[c] = 1;
                else if (sv[c])         m_cnt[c] = 0;
                else if (m_arr[c]) begin
                    if (m_cnt[c] < CMAX) m_cnt[c] = m_cnt[c] + 1;
                    else                 m_ovf = 1;
                end
                m_hist[c] = {m_hist[c][62:0], raw[c]};
                all_diff = 1;
                for (int k = 2; k < DEB + 2; k++)
                    if (m_hist[c][k] == m_stable[c]) all_diff = 0;
                if (all_diff) begin
                    m_stable[c] = !m_stable[c];
                    m_arr[c]    = m_stable[c];
                end else begin
                    m_arr[c] = 0;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("sensor1",  32'(sensor1),  32'(m_stable[0] | (HOLD && m_cnt[0] != 0)));
        chk("sensor2",  32'(sensor2),  32'(m_stable[1] | (HOLD && m_cnt[1] != 0)));
        chk("arrive1",  32'(arrive1),  32'(m_arr[0]));
        chk("arrive2",  32'(arrive2),  32'(m_arr[1]));
        chk("count1",   32'(count1),   32'(m_cnt[0]));
        chk("count2",   32'(count2),   32'(m_cnt[1]));
        chk("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    initial begin
        // Reset with both detectors active, then release approach 1 only
        reset = 1'b1; sensor1_raw = 1'b1; sensor2_raw = 1'b1;
        steps(2);
        chk("t1_rst_sensor1", 32'(sensor1), 0);
        chk("t1_rst_count2",  32'(count2), 0);
        reset = 1'b0; sensor2_raw = 1'b0;
        steps(5);
        chk("t1_sensor1_edge5", 32'(sensor1), 0);
        step();
        chk("t2_sensor1_edge6", 32'(sensor1), 1);
        chk("t2_arrive1_edge6", 32'(arrive1), 1);
        step();
        chk("t2_arrive1_edge7", 32'(arrive1), 0);
        chk("t2_count1",        32'(count1), 1);

        // Short glitch must be rejected
        serve1 = 1'b1; step(); serve1 = 1'b0;
        sensor1_raw = 1'b0; steps(7);
        sensor1_raw = 1'b1; steps(3);
        sensor1_raw = 1'b0; steps(8);
        chk("t3_sensor1", 32'(sensor1), 0);
        chk("t3_count1",  32'(count1), 0);

        // Saturation on approach 2
        serve2 = 1'b1; step(); serve2 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            sensor2_raw = 1'b1; steps(7);
            sensor2_raw = 1'b0; steps(7);
        end
        chk("t4_count2_sat", 32'(count2), CMAX);
        chk("t4_overflow",   32'(overflow), 1);
        sensor2_raw = 1'b1; steps(7);
        sensor2_raw = 1'b0; steps(7);
        chk("t4_count2_17th", 32'(count2), CMAX);

        // Serve coinciding with an arrival, then serve alone
        for (int i = 0; i < 3; i++) begin
            sensor1_raw = 1'b1; steps(7);
            sensor1_raw = 1'b0; steps(7);
        end
        chk("t5_count1_3", 32'(count1), 3);
        sensor1_raw = 1'b1; steps(6);
        chk("t5_arrive1", 32'(arrive1), 1);
        serve1 = 1'b1; step();
        chk("t5_serve_arrive", 32'(count1), 1);
        step();
        chk("t5_serve_only", 32'(count1), 0);
        serve1 = 1'b0;

        // Demand after the vehicle leaves
        sensor1_raw = 1'b0; steps(7);
        sensor1_raw = 1'b1; steps(7);
        sensor1_raw = 1'b0; steps(5);
        chk("t6_sensor1_edge5", 32'(sensor1), 1);
        step();
        chk("t6_sensor1_edge6", 32'(sensor1), 32'(HOLD));
        step();
        serve1 = 1'b1; step(); serve1 = 1'b0;
        chk("t6_sensor1_served", 32'(sensor1), 0);

        // Reset in the middle of qualifying a rising edge
        steps(3);
        sensor1_raw = 1'b1; steps(5);
        reset = 1'b1; sensor1_raw = 1'b0; step();
        chk("t7_count1",   32'(count1), 0);
        chk("t7_count2",   32'(count2), 0);
        chk("t7_overflow", 32'(overflow), 0);
        reset = 1'b0; steps(8);
        chk("t7_no_arrive", 32'(arrive1), 0);

        // Randomized detectors and serves
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(5, 0) == 0) sensor1_raw = ~sensor1_raw;
            if ($urandom_range(5, 0) == 0) sensor2_raw = ~sensor2_raw;
            serve1 = ($urandom_range(11, 0) == 0);
            serve2 = ($urandom_range(11, 0) == 0);
            reset  = ($urandom_range(299, 0) == 0);
            step();
        end
        reset = 1'b0; serve1 = 1'b0; serve2 = 1'b0;
        steps(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
